// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// input_debouncer
// Multi-channel synchroniser and debouncer for asynchronous board inputs,
// with optional one-cycle rise/fall pulses (macro INPUT_DEBOUNCER_EDGE_EN).
// Revision: 1.0
// ============================================================================
module input_debouncer #(
   parameter int                  CHANNELS      = 3,
   parameter int                  SYNC_STAGES   = 2,
   parameter int                  STABLE_CYCLES = 120000,
   parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{1'b0}}
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [CHANNELS-1:0] raw_in,
   output logic [CHANNELS-1:0] debounced,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_change
);

   localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
   logic [CNT_W-1:0]    cnt_q  [CHANNELS];
   logic [CNT_W-1:0]    cnt_d  [CHANNELS];
   logic [CHANNELS-1:0] debounced_q;
   logic [CHANNELS-1:0] debounced_d;
   logic [CHANNELS-1:0] sync_out;

   always_comb begin
      sync_d[0] = raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Any sample matching the current state restarts the count from zero.
   always_comb begin
      debounced_d = debounced_q;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = '0;
         if (enable && (sync_out[i] != debounced_q[i])) begin
            if (cnt_q[i] == CNT_LAST) begin
               debounced_d[i] = sync_out[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= RESET_VALUE;
         end
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
         debounced_q <= RESET_VALUE;
      end else begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_d[k];
         end
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         debounced_q <= debounced_d;
      end
   end

   assign debounced = debounced_q;

`ifdef INPUT_DEBOUNCER_EDGE_EN
   logic [CHANNELS-1:0] rise_q;
   logic [CHANNELS-1:0] rise_d;
   logic [CHANNELS-1:0] fall_q;
   logic [CHANNELS-1:0] fall_d;
   logic                any_change_q;
   logic                any_change_d;

   // Pulses are derived from the next state so they land with the flip itself.
   always_comb begin
      rise_d       = debounced_d & ~debounced_q;
      fall_d       = ~debounced_d & debounced_q;
      any_change_d = |(rise_d | fall_d);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rise_q       <= '0;
         fall_q       <= '0;
         any_change_q <= 1'b0;
      end else begin
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         any_change_q <= any_change_d;
      end
   end

   assign rise       = rise_q;
   assign fall       = fall_q;
   assign any_change = any_change_q;
`else
   assign rise       = {CHANNELS{1'b0}};
   assign fall       = {CHANNELS{1'b0}};
   assign any_change = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// tb_input_debouncer
// Randomised and directed bench for input_debouncer against a streak-length
// reference model; two instances with different reset levels share stimulus.
// Revision: 1.0
// ============================================================================
module tb_input_debouncer;

   localparam int         CH  = 3;
   localparam int         SS  = 2;
   localparam int         SC  = 4;
   localparam logic [2:0] RV0 = 3'b000;
   localparam logic [2:0] RV1 = 3'b101;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       en    = 1'b0;
   logic [2:0] raw   = 3'b000;

   logic [2:0] deb0, rise0, fall0;
   logic       any0;
   logic [2:0] deb1, rise1, fall1;
   logic       any1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   input_debouncer #(
      .CHANNELS      (CH),
      .SYNC_STAGES   (SS),
      .STABLE_CYCLES (SC),
      .RESET_VALUE   (RV0)
   ) u_dut0 (
      .clock      (clk),
      .reset_n    (rst_n),
      .enable     (en),
      .raw_in     (raw),
      .debounced  (deb0),
      .rise       (rise0),
      .fall       (fall0),
      .any_change (any0)
   );

   input_debouncer #(
      .CHANNELS      (CH),
      .SYNC_STAGES   (SS),
      .STABLE_CYCLES (SC),
      .RESET_VALUE   (RV1)
   ) u_dut1 (
      .clock      (clk),
      .reset_n    (rst_n),
      .enable     (en),
      .raw_in     (raw),
      .debounced  (deb1),
      .rise       (rise1),
      .fall       (fall1),
      .any_change (any1)
   );

   // Reference: each pin value reaches the decision point SS edges later;
   // the state flips once SC consecutive enabled samples disagree with it.
   logic [2:0] m_pipe   [2][SS];
   int         m_streak [2][CH];
   logic [2:0] m_deb    [2];
   logic [2:0] m_rise   [2];
   logic [2:0] m_fall   [2];
   logic       m_any    [2];

`ifdef INPUT_DEBOUNCER_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [2:0] s;
      logic [2:0] nxt;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            for (int k = 0; k < SS; k++) m_pipe[d][k] = (d == 0) ? RV0 : RV1;
            for (int c = 0; c < CH; c++) m_streak[d][c] = 0;
            m_deb[d]  = (d == 0) ? RV0 : RV1;
            m_rise[d] = 3'b000;
            m_fall[d] = 3'b000;
            m_any[d]  = 1'b0;
         end else begin
            s   = m_pipe[d][SS-1];
            nxt = m_deb[d];
            for (int c = 0; c < CH; c++) begin
               if (en && (s[c] != m_deb[d][c])) begin
                  m_streak[d][c] = m_streak[d][c] + 1;
                  if (m_streak[d][c] == SC) begin
                     nxt[c]         = s[c];
                     m_streak[d][c] = 0;
                  end
               end else begin
                  m_streak[d][c] = 0;
               end
            end
            m_rise[d] = nxt & ~m_deb[d];
            m_fall[d] = ~nxt & m_deb[d];
            m_any[d]  = |(m_rise[d] | m_fall[d]);
            m_deb[d]  = nxt;
            for (int k = SS - 1; k > 0; k--) m_pipe[d][k] = m_pipe[d][k-1];
            m_pipe[d][0] = raw;
         end
      end
   endtask

   // One clock edge: advance the model, then compare away from the edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("deb0",  {29'd0, deb0}, {29'd0, m_deb[0]});
      check("deb1",  {29'd0, deb1}, {29'd0, m_deb[1]});
      check("rise0", {29'd0, rise0}, EDGE_EN ? {29'd0, m_rise[0]} : 32'd0);
      check("fall0", {29'd0, fall0}, EDGE_EN ? {29'd0, m_fall[0]} : 32'd0);
      check("any0",  {31'd0, any0},  EDGE_EN ? {31'd0, m_any[0]}  : 32'd0);
      check("rise1", {29'd0, rise1}, EDGE_EN ? {29'd0, m_rise[1]} : 32'd0);
      check("fall1", {29'd0, fall1}, EDGE_EN ? {29'd0, m_fall[1]} : 32'd0);
      check("any1",  {31'd0, any1},  EDGE_EN ? {31'd0, m_any[1]}  : 32'd0);
      check("excl0", {29'd0, rise0 & fall0}, 32'd0);
   endtask

   initial begin
      int seg;

      // Reset state
      rst_n = 1'b0;
      raw   = 3'b000;
      en    = 1'b1;
      @(negedge clk);
      tick();
      check("rst_deb0", {29'd0, deb0}, {29'd0, RV0});
      check("rst_deb1", {29'd0, deb1}, {29'd0, RV1});
      rst_n = 1'b1;
      repeat (12) tick();

      // Clean press on channel 0
      raw = 3'b001;
      repeat (5) tick();
      check("press_early", {29'd0, deb0}, 32'd0);
      tick();
      check("press_deb", {29'd0, deb0}, 32'd1);
      check("press_rise", {29'd0, rise0}, EDGE_EN ? 32'd1 : 32'd0);
      check("press_any", {31'd0, any0}, EDGE_EN ? 32'd1 : 32'd0);
      tick();
      check("press_rise_end", {29'd0, rise0}, 32'd0);
      check("press_any_end", {31'd0, any0}, 32'd0);

      // Release, then bounce on channel 1: highs of 1,3,2 separated by single lows
      raw = 3'b000;
      repeat (10) tick();
      raw = 3'b010; tick(); raw = 3'b000; tick();
      raw = 3'b010; repeat (3) tick(); raw = 3'b000; tick();
      raw = 3'b010; repeat (2) tick(); raw = 3'b000; tick();
      raw = 3'b010;
      repeat (5) tick();
      check("bounce_early", {29'd0, deb0}, 32'd0);
      tick();
      check("bounce_deb", {29'd0, deb0}, 32'd2);
      repeat (4) tick();

      // Simultaneous press on all channels, then channel 2 releases
      raw = 3'b000;
      repeat (10) tick();
      raw = 3'b111;
      repeat (20) tick();
      check("simul_deb", {29'd0, deb0}, 32'd7);
      raw = 3'b011;
      repeat (10) tick();
      check("simul_release", {29'd0, deb0}, 32'd3);

      // Reset in the middle of a count
      raw = 3'b000;
      repeat (10) tick();
      raw = 3'b001;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      check("midrst_deb0", {29'd0, deb0}, 32'd0);
      check("midrst_rise0", {29'd0, rise0}, 32'd0);
      check("midrst_any0", {31'd0, any0}, 32'd0);
      rst_n = 1'b1;
      repeat (10) tick();
      check("midrst_final", {29'd0, deb0}, 32'd1);

      // Enable freeze
      raw = 3'b000;
      repeat (10) tick();
      en  = 1'b0;
      raw = 3'b001;
      repeat (50) tick();
      check("freeze_hold", {29'd0, deb0}, 32'd0);
      en = 1'b1;
      repeat (3) tick();
      check("freeze_early", {29'd0, deb0}, 32'd0);
      tick();
      check("freeze_release", {29'd0, deb0}, 32'd1);

      // Random segments: short ones bounce, long ones settle
      for (int n = 0; n < 300; n++) begin
         raw = 3'($urandom);
         en  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 39) == 0) rst_n = 1'b0;
         seg = $urandom_range(1, 9);
         tick();
         rst_n = 1'b1;
         repeat (seg - 1) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
